// File: rtl/pipelined_sequential_subtractor.sv
// Borrow-ripple N-bit subtractor resolving one W-bit chunk per stage; latency STAGES edges, one op per clock.
// No backpressure: en=0 freezes every register (outputs included) and the input is not sampled.
module pipelined_sequential_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  output logic [N-1:0] d,
  output logic         bout
);
  localparam int STAGES = N / W;

  if (N % W != 0) begin : g_bad_width
    $error("N (%0d) must be a multiple of W (%0d)", N, W);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Only the not-yet-consumed upper chunks of a/b reach stage k.
    localparam int IW = N - k * W;

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic [N-1:0]  d_in;
    logic          brw_in;
    logic          vld_in;
    logic [W:0]    diff;
    logic [N-1:0]  d_d;
    logic [N-1:0]  d_q;
    logic          brw_d;
    logic          brw_q;
    logic          vld_d;
    logic          vld_q;

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b;
      assign d_in   = '0;
      assign brw_in = bin;
      assign vld_in = in_valid;
    end else begin : g_src
      assign a_in   = g_st[k-1].g_fwd.a_q;
      assign b_in   = g_st[k-1].g_fwd.b_q;
      assign d_in   = g_st[k-1].d_q;
      assign brw_in = g_st[k-1].brw_q;
      assign vld_in = g_st[k-1].vld_q;
    end

    // Bit W of the widened difference is set exactly when the chunk underflows.
    always_comb begin
      diff  = {1'b0, a_in[W-1:0]} - {1'b0, b_in[W-1:0]} - {{W{1'b0}}, brw_in};
      d_d   = d_in | (N'(diff[W-1:0]) << (k * W));
      brw_d = diff[W];
      vld_d = vld_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        d_q   <= '0;
        brw_q <= 1'b0;
        vld_q <= 1'b0;
      end else if (en) begin
        d_q   <= d_d;
        brw_q <= brw_d;
        vld_q <= vld_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-W-1:0] a_d;
      logic [IW-W-1:0] a_q;
      logic [IW-W-1:0] b_d;
      logic [IW-W-1:0] b_q;

      always_comb begin
        a_d = a_in[IW-1:W];
        b_d = b_in[IW-1:W];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  // Completed chunks accumulate in place, so the last stage's registers are the outputs.
  assign d         = g_st[STAGES-1].d_q;
  assign bout      = g_st[STAGES-1].brw_q;
  assign out_valid = g_st[STAGES-1].vld_q;

endmodule

// File: tb/tb_pipelined_sequential_subtractor.sv
// Bench for pipelined_sequential_subtractor: directed cases, a long back-to-back run, en stalls,
// asynchronous reset mid-stream and a random phase, all against a delay-line arithmetic model.
module tb_pipelined_sequential_subtractor;
  localparam int N = 32;
  localparam int W = 8;
  localparam int S = N / W;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic [N-1:0] d;
  logic         bout;

  int checks = 0;
  int errors = 0;

  // Reference: each accepted input becomes a finished result that simply waits S advances.
  logic         m_vld [S];
  logic [N-1:0] m_d   [S];
  logic         m_b   [S];

  pipelined_sequential_subtractor #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .d         (d),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < S; i++) begin
      m_vld[i] = 1'b0;
      m_d[i]   = '0;
      m_b[i]   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, N'(out_valid), N'(m_vld[S-1]));
    chk({tag, ".d"}, d, m_d[S-1]);
    chk({tag, ".bout"}, N'(bout), N'(m_b[S-1]));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check on the falling edge.
  task automatic cyc(input logic e, input logic v, input logic [N-1:0] ai,
                     input logic [N-1:0] bi, input logic bn, input string tag);
    logic [N:0] full;
    en = e; in_valid = v; a = ai; b = bi; bin = bn;
    @(posedge clk);
    if (e && rstn) begin
      full = {1'b0, ai} - {1'b0, bi} - (N + 1)'(bn);
      for (int i = S - 1; i > 0; i--) begin
        m_vld[i] = m_vld[i-1];
        m_d[i]   = m_d[i-1];
        m_b[i]   = m_b[i-1];
      end
      m_vld[0] = v;
      m_d[0]   = full[N-1:0];
      m_b[0]   = full[N];
    end
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0, 1'b0, tag);
  endtask

  initial begin
    logic [N-1:0] sa;
    logic [N-1:0] sb;
    logic         sbin;

    rstn = 1'b0; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("reset.out_valid", N'(out_valid), '0);
    chk("reset.d", d, '0);
    chk("reset.bout", N'(bout), '0);
    rstn = 1'b1;

    // Single op: visible after the fourth edge counting the sample edge, then gone.
    cyc(1'b1, 1'b1, 32'd333, 32'd50, 1'b0, "t1");
    idle(2, "t1");
    idle(1, "t1");
    chk("t1.out_valid", N'(out_valid), N'(1));
    chk("t1.d", d, 32'd283);
    chk("t1.bout", N'(bout), '0);
    idle(1, "t1");
    chk("t1.out_valid_drop", N'(out_valid), '0);

    // Wrap-around cases.
    cyc(1'b1, 1'b1, 32'd0, 32'd1, 1'b0, "t2");
    cyc(1'b1, 1'b1, 32'd5, 32'd5, 1'b1, "t2");
    idle(2, "t2");
    chk("t2.zero_minus_one.d", d, 32'hFFFF_FFFF);
    chk("t2.zero_minus_one.bout", N'(bout), N'(1));
    idle(1, "t2");
    chk("t2.equal_with_bin.d", d, 32'hFFFF_FFFF);
    chk("t2.equal_with_bin.bout", N'(bout), N'(1));

    // Borrow ripples through three chunks.
    cyc(1'b1, 1'b1, 32'h0100_0000, 32'd1, 1'b1, "t3");
    idle(3, "t3");
    chk("t3.cross_chunk.d", d, 32'h00FF_FFFE);
    chk("t3.cross_chunk.bout", N'(bout), '0);
    idle(1, "t3");

    // Back-to-back stream with an en stall in the middle.
    sa = 32'd333; sb = 32'd50; sbin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        for (int j = 0; j < 3; j++) cyc(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), "t5.stall");
      end
      cyc(1'b1, 1'b1, sa, sb, sbin, "t4");
      if (i >= S - 1) chk("t4.continuous_valid", N'(out_valid), N'(1));
      sa = sa + 32'd1318402;
      sb = sb + 32'd182553;
      sbin = ~sbin;
    end
    idle(S, "t4.drain");

    // Asynchronous reset between edges drops in-flight ops.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, $urandom, $urandom, 1'($urandom), "t6.pre");
    #2 rstn = 1'b0;
    #1;
    chk("t6.async.out_valid", N'(out_valid), '0);
    chk("t6.async.d", d, '0);
    chk("t6.async.bout", N'(bout), '0);
    model_clear();
    cyc(1'b1, 1'b1, $urandom, $urandom, 1'b1, "t6.held");
    #2 rstn = 1'b1;
    idle(S + 1, "t6.empty");
    chk("t6.empty.out_valid", N'(out_valid), '0);
    cyc(1'b1, 1'b1, 32'd1000, 32'd1, 1'b1, "t6.first");
    idle(2, "t6.first");
    chk("t6.early.out_valid", N'(out_valid), '0);
    idle(1, "t6.first");
    chk("t6.first.out_valid", N'(out_valid), N'(1));
    chk("t6.first.d", d, 32'd998);

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 4) != 0), 1'($urandom), $urandom, $urandom, 1'($urandom), "rand");
    end
    idle(S, "rand.drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
